// File: rtl/vc_ctrl.sv
// Victim-cache controller: 8-way fully associative, exclusive, true-LRU.
// Owns tag/valid/dirty/age state, drives the data-array write port and the L2 handshake.
module vc_ctrl #(
    parameter int WIDTH = 128,
    parameter int TAGW  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             l1_req,
    input  logic [TAGW-1:0]  l1_addr,
    input  logic             l1_evict,
    input  logic [TAGW-1:0]  l1_evict_addr,
    input  logic             l1_evict_dirty,
    input  logic [WIDTH-1:0] l1_evict_data,
    output logic             l1_resp,
    output logic             l1_hit,
    output logic [WIDTH-1:0] l1_rdata,
    output logic             l1_rdirty,
    output logic             arr_write,
    output logic [2:0]       arr_index,
    output logic [WIDTH-1:0] arr_wdata,
    input  logic [WIDTH-1:0] arr_dout0,
    input  logic [WIDTH-1:0] arr_dout1,
    input  logic [WIDTH-1:0] arr_dout2,
    input  logic [WIDTH-1:0] arr_dout3,
    input  logic [WIDTH-1:0] arr_dout4,
    input  logic [WIDTH-1:0] arr_dout5,
    input  logic [WIDTH-1:0] arr_dout6,
    input  logic [WIDTH-1:0] arr_dout7,
    output logic             l2_read,
    output logic             l2_write,
    output logic [TAGW-1:0]  l2_addr,
    output logic [WIDTH-1:0] l2_wdata,
    input  logic             l2_resp,
    input  logic [WIDTH-1:0] l2_rdata
);

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, INSERT, FETCH, RESP} state_t;

    state_t              state_q, state_d;
    logic [TAGW-1:0]     tag_q [8];
    logic [TAGW-1:0]     tag_d [8];
    logic [7:0]          valid_q, valid_d;
    logic [7:0]          dirty_q, dirty_d;
    logic [7:0][2:0]     age_q, age_d;
    logic [TAGW-1:0]     req_addr_q, req_addr_d;
    logic                ev_q, ev_d;
    logic [TAGW-1:0]     ev_addr_q, ev_addr_d;
    logic                ev_dirty_q, ev_dirty_d;
    logic [WIDTH-1:0]    ev_data_q, ev_data_d;
    logic [2:0]          tgt_q, tgt_d;
    logic [WIDTH-1:0]    rdata_q, rdata_d;
    logic                hit_q, hit_d;
    logic                rdirty_q, rdirty_d;

    logic [WIDTH-1:0]    dout [8];
    logic                hit_any;
    logic [2:0]          hit_way;
    logic                inv_any;
    logic [2:0]          inv_way, lru_way, vic_way;

    assign dout[0] = arr_dout0;
    assign dout[1] = arr_dout1;
    assign dout[2] = arr_dout2;
    assign dout[3] = arr_dout3;
    assign dout[4] = arr_dout4;
    assign dout[5] = arr_dout5;
    assign dout[6] = arr_dout6;
    assign dout[7] = arr_dout7;

    assign l1_rdata  = rdata_q;
    assign l1_hit    = hit_q;
    assign l1_rdirty = rdirty_q;

    // Make w the MRU way; ways younger than it age by one.
    function automatic logic [7:0][2:0] touch(input logic [7:0][2:0] a, input logic [2:0] w);
        logic [7:0][2:0] r;
        r = a;
        for (int i = 0; i < 8; i++) begin
            if (a[i] < a[w]) r[i] = a[i] + 3'd1;
        end
        r[w] = 3'd0;
        return r;
    endfunction

    // Make w the LRU way; ways older than it get one step younger.
    function automatic logic [7:0][2:0] demote(input logic [7:0][2:0] a, input logic [2:0] w);
        logic [7:0][2:0] r;
        r = a;
        for (int i = 0; i < 8; i++) begin
            if (a[i] > a[w]) r[i] = a[i] - 3'd1;
        end
        r[w] = 3'd7;
        return r;
    endfunction

    always_comb begin
        hit_any = 1'b0;
        hit_way = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (valid_q[i] && (tag_q[i] == req_addr_q)) begin
                hit_any = 1'b1;
                hit_way = 3'(i);
            end
        end
    end

    // Replacement target: lowest invalid way, else the age-7 way.
    always_comb begin
        lru_way = 3'd0;
        inv_any = 1'b0;
        inv_way = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (age_q[i] == 3'd7) lru_way = 3'(i);
        end
        for (int i = 7; i >= 0; i--) begin
            if (!valid_q[i]) begin
                inv_any = 1'b1;
                inv_way = 3'(i);
            end
        end
        vic_way = inv_any ? inv_way : lru_way;
    end

    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        age_d      = age_q;
        req_addr_d = req_addr_q;
        ev_d       = ev_q;
        ev_addr_d  = ev_addr_q;
        ev_dirty_d = ev_dirty_q;
        ev_data_d  = ev_data_q;
        tgt_d      = tgt_q;
        rdata_d    = rdata_q;
        hit_d      = hit_q;
        rdirty_d   = rdirty_q;
        l1_resp    = 1'b0;
        arr_write  = 1'b0;
        arr_index  = 3'd0;
        arr_wdata  = '0;
        l2_read    = 1'b0;
        l2_write   = 1'b0;
        l2_addr    = '0;
        l2_wdata   = '0;

        case (state_q)
            IDLE: begin
                if (l1_req) begin
                    req_addr_d = l1_addr;
                    ev_d       = l1_evict;
                    ev_addr_d  = l1_evict_addr;
                    ev_dirty_d = l1_evict_dirty;
                    ev_data_d  = l1_evict_data;
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit_any) begin
                    // Array output is still the pre-swap line this cycle.
                    rdata_d  = dout[hit_way];
                    rdirty_d = dirty_q[hit_way];
                    hit_d    = 1'b1;
                    if (ev_q) begin
                        arr_write        = 1'b1;
                        arr_index        = hit_way;
                        arr_wdata        = ev_data_q;
                        tag_d[hit_way]   = ev_addr_q;
                        valid_d[hit_way] = 1'b1;
                        dirty_d[hit_way] = ev_dirty_q;
                        age_d            = touch(age_q, hit_way);
                    end else begin
                        valid_d[hit_way] = 1'b0;
                        age_d            = demote(age_q, hit_way);
                    end
                    state_d = RESP;
                end else if (!ev_q) begin
                    state_d = FETCH;
                end else begin
                    tgt_d   = vic_way;
                    state_d = (valid_q[vic_way] && dirty_q[vic_way]) ? WB : INSERT;
                end
            end
            WB: begin
                l2_write = 1'b1;
                l2_addr  = tag_q[tgt_q];
                l2_wdata = dout[tgt_q];
                if (l2_resp) state_d = INSERT;
            end
            INSERT: begin
                arr_write      = 1'b1;
                arr_index      = tgt_q;
                arr_wdata      = ev_data_q;
                tag_d[tgt_q]   = ev_addr_q;
                valid_d[tgt_q] = 1'b1;
                dirty_d[tgt_q] = ev_dirty_q;
                age_d          = touch(age_q, tgt_q);
                state_d        = FETCH;
            end
            FETCH: begin
                l2_read = 1'b1;
                l2_addr = req_addr_q;
                if (l2_resp) begin
                    rdata_d  = l2_rdata;
                    hit_d    = 1'b0;
                    rdirty_d = 1'b0;
                    state_d  = RESP;
                end
            end
            RESP: begin
                l1_resp = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            for (int i = 0; i < 8; i++) begin
                tag_q[i] <= '0;
                age_q[i] <= 3'(i);
            end
            req_addr_q <= '0;
            ev_q       <= 1'b0;
            ev_addr_q  <= '0;
            ev_dirty_q <= 1'b0;
            ev_data_q  <= '0;
            tgt_q      <= 3'd0;
            rdata_q    <= '0;
            hit_q      <= 1'b0;
            rdirty_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            age_q      <= age_d;
            req_addr_q <= req_addr_d;
            ev_q       <= ev_d;
            ev_addr_q  <= ev_addr_d;
            ev_dirty_q <= ev_dirty_d;
            ev_data_q  <= ev_data_d;
            tgt_q      <= tgt_d;
            rdata_q    <= rdata_d;
            hit_q      <= hit_d;
            rdirty_q   <= rdirty_d;
        end
    end

endmodule

// File: tb/tb_vc_ctrl.sv
// Bench for vc_ctrl: behavioural victim-cache model feeds a scoreboard of expected
// responses; a simple data array and L2 memory surround the controller.
module tb_vc_ctrl;
    localparam int WIDTH = 128;
    localparam int TAGW  = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             l1_req, l1_evict, l1_evict_dirty;
    logic [TAGW-1:0]  l1_addr, l1_evict_addr;
    logic [WIDTH-1:0] l1_evict_data;
    logic             l1_resp, l1_hit, l1_rdirty;
    logic [WIDTH-1:0] l1_rdata;
    logic             arr_write;
    logic [2:0]       arr_index;
    logic [WIDTH-1:0] arr_wdata;
    logic [WIDTH-1:0] arr_mem [8];
    logic             l2_read, l2_write, l2_resp;
    logic [TAGW-1:0]  l2_addr;
    logic [WIDTH-1:0] l2_wdata, l2_rdata;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (arr_write) arr_mem[arr_index] <= arr_wdata;
    end

    vc_ctrl #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst_n(rst_n),
        .l1_req(l1_req), .l1_addr(l1_addr), .l1_evict(l1_evict),
        .l1_evict_addr(l1_evict_addr), .l1_evict_dirty(l1_evict_dirty),
        .l1_evict_data(l1_evict_data),
        .l1_resp(l1_resp), .l1_hit(l1_hit), .l1_rdata(l1_rdata), .l1_rdirty(l1_rdirty),
        .arr_write(arr_write), .arr_index(arr_index), .arr_wdata(arr_wdata),
        .arr_dout0(arr_mem[0]), .arr_dout1(arr_mem[1]), .arr_dout2(arr_mem[2]),
        .arr_dout3(arr_mem[3]), .arr_dout4(arr_mem[4]), .arr_dout5(arr_mem[5]),
        .arr_dout6(arr_mem[6]), .arr_dout7(arr_mem[7]),
        .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_resp(l2_resp), .l2_rdata(l2_rdata)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model of the victim cache contents.
    logic [TAGW-1:0]  m_tag   [8];
    logic             m_val   [8];
    logic             m_dirty [8];
    logic [2:0]       m_age   [8];
    logic [WIDTH-1:0] m_data  [8];
    logic [WIDTH-1:0] l2mem [int];

    typedef struct {
        logic             hit;
        logic [WIDTH-1:0] data;
        logic             dirty;
        logic             wb;
        logic [TAGW-1:0]  wb_addr;
        logic [WIDTH-1:0] wb_data;
        int               n_arrw;
        logic [2:0]       arrw_idx;
        logic [WIDTH-1:0] arrw_data;
        logic             fetch;
        logic [TAGW-1:0]  rd_addr;
        int               lat;
    } exp_t;
    exp_t sb [$];

    function automatic logic [WIDTH-1:0] l2_val(input logic [TAGW-1:0] a);
        if (l2mem.exists(int'(a))) return l2mem[int'(a)];
        return {8{4'hC, a}};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_tag[i] = '0; m_val[i] = 1'b0; m_dirty[i] = 1'b0; m_age[i] = 3'(i);
        end
    endtask

    task automatic model_touch(input int w);
        logic [2:0] aw = m_age[w];
        for (int i = 0; i < 8; i++) if (m_age[i] < aw) m_age[i] = m_age[i] + 3'd1;
        m_age[w] = 3'd0;
    endtask

    task automatic model_demote(input int w);
        logic [2:0] aw = m_age[w];
        for (int i = 0; i < 8; i++) if (m_age[i] > aw) m_age[i] = m_age[i] - 3'd1;
        m_age[w] = 3'd7;
    endtask

    task automatic predict(input logic [TAGW-1:0] addr, input logic ev, input logic [TAGW-1:0] ev_addr,
                           input logic ev_dirty, input logic [WIDTH-1:0] ev_data, input int d,
                           output exp_t e);
        int h = -1;
        int t = -1;
        e = '{default: 0};
        for (int i = 0; i < 8; i++) if (m_val[i] && m_tag[i] == addr) h = i;
        if (h >= 0) begin
            e.hit = 1'b1; e.data = m_data[h]; e.dirty = m_dirty[h]; e.lat = 2;
            if (ev) begin
                m_tag[h] = ev_addr; m_val[h] = 1'b1; m_dirty[h] = ev_dirty; m_data[h] = ev_data;
                model_touch(h);
                e.n_arrw = 1; e.arrw_idx = 3'(h); e.arrw_data = ev_data;
            end else begin
                m_val[h] = 1'b0;
                model_demote(h);
            end
        end else begin
            e.lat = 3 + d; e.fetch = 1'b1; e.rd_addr = addr; e.data = l2_val(addr);
            if (ev) begin
                for (int i = 7; i >= 0; i--) if (!m_val[i]) t = i;
                if (t < 0) for (int i = 0; i < 8; i++) if (m_age[i] == 3'd7) t = i;
                e.lat += 1;
                if (m_val[t] && m_dirty[t]) begin
                    e.wb = 1'b1; e.wb_addr = m_tag[t]; e.wb_data = m_data[t]; e.lat += d + 1;
                end
                m_tag[t] = ev_addr; m_val[t] = 1'b1; m_dirty[t] = ev_dirty; m_data[t] = ev_data;
                model_touch(t);
                e.n_arrw = 1; e.arrw_idx = 3'(t); e.arrw_data = ev_data;
            end
        end
    endtask

    task automatic run_req(input logic [TAGW-1:0] addr, input logic ev, input logic [TAGW-1:0] ev_addr,
                           input logic ev_dirty, input logic [WIDTH-1:0] ev_data, input int d);
        exp_t e, got;
        int cyc = 0, cnt_w = 0, cnt_r = 0, n_aw = 0;
        logic done = 1'b0, saw_w = 1'b0, saw_r = 1'b0;
        logic [2:0] aw_idx = '0;
        logic [WIDTH-1:0] aw_data = '0;
        predict(addr, ev, ev_addr, ev_dirty, ev_data, d, e);
        sb.push_back(e);
        @(negedge clk);
        l1_req = 1'b1; l1_addr = addr; l1_evict = ev;
        l1_evict_addr = ev_addr; l1_evict_dirty = ev_dirty; l1_evict_data = ev_data;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            l2_resp  = 1'b0;
            l2_rdata = {4{$urandom}};
            if (arr_write) begin n_aw++; aw_idx = arr_index; aw_data = arr_wdata; end
            check_val("l2_rw_excl", WIDTH'(l2_read & l2_write), '0);
            if (l2_write) begin
                saw_w = 1'b1;
                check_val("wb_addr", WIDTH'(l2_addr), WIDTH'(e.wb_addr));
                check_val("wb_data", l2_wdata, e.wb_data);
                if (cnt_w == d) begin l2_resp = 1'b1; l2mem[int'(l2_addr)] = l2_wdata; end
                cnt_w++;
            end
            if (l2_read) begin
                saw_r = 1'b1;
                check_val("rd_addr", WIDTH'(l2_addr), WIDTH'(e.rd_addr));
                if (cnt_r == d) begin l2_resp = 1'b1; l2_rdata = l2_val(l2_addr); end
                cnt_r++;
            end
            if (l1_resp) begin
                done = 1'b1;
                l1_req = 1'b0; l1_evict = 1'b0;
                got = sb.pop_front();
                check_val("resp_hit", WIDTH'(l1_hit), WIDTH'(got.hit));
                check_val("resp_data", l1_rdata, got.data);
                check_val("resp_dirty", WIDTH'(l1_rdirty), WIDTH'(got.dirty));
                check_val("latency", WIDTH'(cyc), WIDTH'(got.lat));
                check_val("arr_write_cnt", WIDTH'(n_aw), WIDTH'(got.n_arrw));
                if (got.n_arrw > 0) begin
                    check_val("arr_index", WIDTH'(aw_idx), WIDTH'(got.arrw_idx));
                    check_val("arr_wdata", aw_data, got.arrw_data);
                end
                check_val("l2_write_seen", WIDTH'(saw_w), WIDTH'(got.wb));
                check_val("l2_read_seen", WIDTH'(saw_r), WIDTH'(got.fetch));
            end
        end
        check_val("resp_timeout", WIDTH'(done), WIDTH'(1));
        if (!done) begin
            l1_req = 1'b0; l1_evict = 1'b0; l2_resp = 1'b0;
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            @(negedge clk);
            check_val("resp_pulse", WIDTH'(l1_resp), '0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_l1_resp"}, WIDTH'(l1_resp), '0);
        check_val({tag, "_l1_hit"}, WIDTH'(l1_hit), '0);
        check_val({tag, "_l1_rdata"}, l1_rdata, '0);
        check_val({tag, "_l1_rdirty"}, WIDTH'(l1_rdirty), '0);
        check_val({tag, "_arr_write"}, WIDTH'(arr_write), '0);
        check_val({tag, "_arr_index"}, WIDTH'(arr_index), '0);
        check_val({tag, "_arr_wdata"}, arr_wdata, '0);
        check_val({tag, "_l2_read"}, WIDTH'(l2_read), '0);
        check_val({tag, "_l2_write"}, WIDTH'(l2_write), '0);
        check_val({tag, "_l2_addr"}, WIDTH'(l2_addr), '0);
        check_val({tag, "_l2_wdata"}, l2_wdata, '0);
    endtask

    logic [WIDTH-1:0] dat_a, dat_b;
    logic [TAGW-1:0]  held;
    logic [TAGW-1:0]  pool [$];

    initial begin
        rst_n = 1'b0; l1_req = 1'b0; l1_addr = '0; l1_evict = 1'b0;
        l1_evict_addr = '0; l1_evict_dirty = 1'b0; l1_evict_data = '0;
        l2_resp = 1'b0; l2_rdata = '0;
        model_reset();
        dat_a = {32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 32'hAAAA_0004};
        dat_b = {32'hBBBB_0001, 32'hBBBB_0002, 32'hBBBB_0003, 32'hBBBB_0004};
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Cold miss, insert-then-hit, swap.
        run_req(12'h123, 1'b0, 12'h000, 1'b0, '0, 2);
        run_req(12'h010, 1'b1, 12'h0A5, 1'b0, dat_a, 1);
        run_req(12'h0A5, 1'b0, 12'h000, 1'b0, '0, 0);
        run_req(12'h020, 1'b1, 12'h0A5, 1'b0, dat_a, 0);
        run_req(12'h0A5, 1'b1, 12'h0B6, 1'b1, dat_b, 0);

        // Fill with dirty victims, then force a writeback with a slow L2.
        for (int i = 0; i < 7; i++)
            run_req(12'h300 + 12'(i), 1'b1, 12'h200 + 12'(i), 1'b1, {4{32'hD000_0000 + 32'(i)}}, 0);
        run_req(12'h310, 1'b1, 12'h2F0, 1'b1, {4{32'hE000_0001}}, 5);

        // Hit without evict frees a way; next victim lands there without writeback.
        run_req(12'h202, 1'b0, 12'h000, 1'b0, '0, 0);
        run_req(12'h311, 1'b1, 12'h3F0, 1'b0, {4{32'hF000_0002}}, 1);

        // Random traffic over fresh victims and a pool of held lines.
        for (int k = 0; k < 40; k++) begin
            logic             ev;
            logic [TAGW-1:0]  ra;
            ev = 1'($urandom_range(0, 1));
            if (pool.size() > 0 && $urandom_range(0, 1) == 1)
                ra = pool[$urandom_range(0, pool.size() - 1)];
            else
                ra = 12'h800 + 12'($urandom_range(0, 255));
            run_req(ra, ev, 12'h400 + 12'(k), 1'($urandom_range(0, 1)),
                    {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 3)));
            if (ev) pool.push_back(12'h400 + 12'(k));
        end

        // Reset while a fetch is outstanding.
        held = '0;
        for (int i = 0; i < 8; i++) if (m_val[i]) held = m_tag[i];
        @(negedge clk);
        l1_req = 1'b1; l1_addr = 12'h7FF; l1_evict = 1'b0;
        for (int i = 0; i < 10 && !l2_read; i++) @(negedge clk);
        check_val("fetch_before_reset", WIDTH'(l2_read), WIDTH'(1));
        l1_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        run_req(held, 1'b0, 12'h000, 1'b0, '0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/vc_ctrl.md
# vc_ctrl

Controller for the 8-entry fully associative, exclusive victim cache that sits between the L1 data cache and L2. It holds the tag, valid, dirty and LRU state, and drives the write side of the victim-cache data array. It also reads all eight array outputs in parallel. On an L1 miss it looks up the missing line, swaps in the L1's evicted line, writes dirty displaced entries back to L2, and fetches from L2 on a victim-cache miss.

## Interface
- WIDTH, 128, line width in bits.
- TAGW, 12, line address width (16-bit lc3b address, 16-byte lines).

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- l1_req  in  1  miss request, held until l1_resp.
- l1_addr  in  TAGW  line address of missing line.
- l1_evict  in  1  L1 supplies a victim line with this request.
- l1_evict_addr  in  TAGW  victim line address.
- l1_evict_dirty  in  1  victim dirty.
- l1_evict_data  in  WIDTH  victim data.
- l1_resp  out  1  one-cycle completion pulse.
- l1_hit  out  1  line came from victim cache; valid with l1_resp.
- l1_rdata  out  WIDTH  returned line; valid with l1_resp.
- l1_rdirty  out  1  returned line dirty (0 when from L2); valid with l1_resp.
- arr_write  out  1  data array write enable.
- arr_index  out  3  data array way index.
- arr_wdata  out  WIDTH  data array write data.
- arr_dout0..arr_dout7  in  WIDTH each  data array contents of ways 0..7.
- l2_read  out  1  L2 line read request.
- l2_write  out  1  L2 line writeback request.
- l2_addr  out  TAGW  L2 line address.
- l2_wdata  out  WIDTH  writeback data.
- l2_resp  in  1  L2 completion.
- l2_rdata  in  WIDTH  L2 read data; valid with l2_resp.

## Operation
- Per-way state: tag[TAGW], valid, dirty, age[3] (true LRU; 0 = MRU, 7 = LRU). Ages are always a permutation of 0..7.
- Touch(w): every way whose age < age[w] increments; age[w] becomes 0.
- Demote(w): every way whose age > age[w] decrements; age[w] becomes 7.
- Victim target: lowest-numbered invalid way; otherwise the way with age 7.
- States: IDLE, LOOKUP, WB, INSERT, FETCH, RESP.
- IDLE
  - If l1_req=1, latch all l1_* inputs and go to LOOKUP.
- LOOKUP
  - Compare the latched address against all valid tags. At most one way matches.
  - Hit in way h: capture arr_dout[h] into l1_rdata and dirty[h] into l1_rdirty, and set l1_hit.
    - If evict: write the victim into way h (arr_write, tag, valid=1, dirty=evict_dirty), then Touch(h).
    - If no evict: set valid[h]=0, then Demote(h).
    - Go to RESP.
  - Miss without evict: go to FETCH.
  - Miss with evict: pick target t. If valid[t]&dirty[t], go to WB; otherwise go to INSERT.
- WB
  - Drive l2_write=1, l2_addr=tag[t], l2_wdata=arr_dout[t].
  - On l2_resp, go to INSERT.
- INSERT
  - Write the victim into way t: arr_write=1, arr_index=t, arr_wdata=victim data; tag[t], valid[t]=1, dirty[t]=evict_dirty.
  - Touch(t), then go to FETCH.
- FETCH
  - Drive l2_read=1, l2_addr=latched request address.
  - On l2_resp, capture l2_rdata into l1_rdata, set l1_hit=0 and l1_rdirty=0, and go to RESP.
- RESP
  - l1_resp=1 for one cycle, then go to IDLE.
- Exclusivity is guaranteed by L1 and is not checked: a victim address is never already present in the victim cache and never equals its own request address.
- arr_write is high only in a LOOKUP hit with evict, and in INSERT.

## Timing
- Reset (asynchronous, immediate): state=IDLE; every output 0 (including arr_index, l1_rdata, l2_addr and l2_wdata); all valid=0, dirty=0, tag=0; age[i]=i.
  - Reset mid-operation abandons any outstanding L2 request; l2_read and l2_write drop immediately.
  - The data array itself is not cleared.
- Hit latency: accept in IDLE in cycle 0, LOOKUP in cycle 1, l1_resp in cycle 2.
- Miss latency: 3 cycles plus L2 latency, plus one extra L2 transaction if a dirty entry is written back.
- A write issued in a cycle is visible on arr_dout the next cycle. In LOOKUP the returned data is the pre-swap content.
- L2 handshake:
  - l2_read, l2_write, l2_addr and l2_wdata stay stable until the cycle in which l2_resp=1, and are deasserted the following cycle.
  - l2_read and l2_write are never high together.
  - l2_resp outside WB or FETCH is ignored.
- L1 deasserts l1_req in the cycle after l1_resp. l1_req is ignored in every state other than IDLE.

## Test plan
- Cold miss: after reset, request 0x123 with no evict → l2_read=1 with l2_addr=0x123 in cycle 2. Return l2_rdata=D → l1_resp next cycle with l1_hit=0, l1_rdata=D, no arr_write.
- Insert then hit: request 0x010 with clean victim 0x0A5/data A → arr_write at index 0 with data A. Then request 0x0A5 with no evict → l1_resp 2 cycles after accept with l1_hit=1, l1_rdata=A, no L2 activity, way 0 invalid, age[0]=7.
- Swap: with 0x0A5 in way 0, request 0x0A5 with dirty victim 0x0B6/data B → l1_rdata=A, arr_write index 0 data B, tag[0]=0x0B6, dirty[0]=1.
- Dirty writeback: insert 8 dirty victims (ways 0..7), then a 9th → l2_write with way-0 tag and data. Delay l2_resp by 5 cycles → l2_write, l2_addr and l2_wdata stable throughout. Then INSERT at index 0, then l2_read.
- Invalid-first fill: full cache, hit without evict on way 3 → the next victim insertion targets index 3 with no l2_write.
- Reset mid-FETCH: assert rst_n=0 while l2_read=1 → l2_read=0 immediately, all outputs 0. A later request to a previously held tag misses.
